// File: rtl/led_chaser_multi.sv
// rtl/led_chaser_multi.sv - parametrised running-LED driver with prescaler and mode select
//
// Drives a bank of WIDTH LEDs with a moving lit segment. The segment advances
// once every PRESC_DIV clock cycles while enabled. The mode input selects
// rotate-left, rotate-right, bounce or hold.
//
// Optional feature macro: LED_CHASER_FILL_EN. When it is defined, mode 11
// fills the bank from the LSB and then drains it, instead of holding.
//
// Parameters:
//   WIDTH      number of LEDs (>= 2)
//   SEED_ONES  contiguous lit LEDs in the LSB-aligned seed (1..WIDTH-1)
//   PRESC_DIV  clk cycles per pattern step (>= 1)
//   PRESC_W    prescaler counter width (2**PRESC_W >= PRESC_DIV)
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rs_n   in   1      asynchronous active-low reset
//   en     in   1      1 = run, 0 = freeze prescaler and pattern
//   mode   in   2      00 rot-left, 01 rot-right, 10 bounce, 11 hold (or fill/drain)
//   led    out  WIDTH  registered LED pattern
//   step   out  1      high in the cycle led shows a new pattern
//   dir_o  out  1      direction, 0 = toward MSB, 1 = toward LSB
module led_chaser_multi #(
  parameter int WIDTH     = 8,
  parameter int SEED_ONES = 2,
  parameter int PRESC_DIV = 12_500_000,
  parameter int PRESC_W   = 24
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             dir_o
);

  generate
    if (WIDTH < 2 || SEED_ONES < 1 || SEED_ONES > WIDTH - 1) begin : g_bad_shape
      $error("led_chaser_multi: WIDTH must be >= 2 and SEED_ONES within 1..WIDTH-1");
    end
    if (PRESC_DIV < 1 || PRESC_W < 1 || (PRESC_W < 31 && (1 << PRESC_W) < PRESC_DIV)) begin : g_bad_presc
      $error("led_chaser_multi: PRESC_DIV must be >= 1 and fit in PRESC_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    M_ROTL   = 2'b00,
    M_ROTR   = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_t;

  // SEED_ONES ones packed against the LSB.
  localparam logic [WIDTH-1:0]   SEED    = {WIDTH{1'b1}} >> (WIDTH - SEED_ONES);
  localparam logic [PRESC_W-1:0] CNT_MAX = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] cnt, cnt_d;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   led_d;
  logic               dir_d;
  logic               step_d;
  logic               mode_chg;
  logic               tick;

`ifdef LED_CHASER_FILL_EN
  logic               fill, fill_d;
  logic [WIDTH-1:0]   fill_nxt;
  logic [WIDTH-1:0]   drain_nxt;
`endif

  always_comb begin
    mode_chg = (mode != mode_q);
    // A prescaler wrap that lands on a mode change is dropped; the reload wins.
    tick     = en && (cnt == CNT_MAX) && !mode_chg;

    led_d    = led;
    dir_d    = dir_o;
    cnt_d    = cnt;
    step_d   = 1'b0;
`ifdef LED_CHASER_FILL_EN
    fill_d    = fill;
    fill_nxt  = {led[WIDTH-2:0], 1'b1};
    drain_nxt = {led[WIDTH-2:0], 1'b0};
`endif

    if (mode_chg) begin
      // Any mode change restarts the pattern from the seed, even while frozen.
      led_d  = SEED;
      dir_d  = 1'b0;
      cnt_d  = '0;
`ifdef LED_CHASER_FILL_EN
      fill_d = 1'b1;
`endif
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_t'(mode_q))
          M_ROTL: begin
            led_d = {led[WIDTH-2:0], led[WIDTH-1]};
            dir_d = 1'b0;
          end
          M_ROTR: begin
            led_d = {led[0], led[WIDTH-1:1]};
            dir_d = 1'b1;
          end
          M_BOUNCE: begin
            // Turn around when the segment touches an end, so popcount is preserved.
            if (!dir_o) begin
              if (led[WIDTH-1]) begin
                dir_d = 1'b1;
                led_d = led >> 1;
              end else begin
                led_d = led << 1;
              end
            end else begin
              if (led[0]) begin
                dir_d = 1'b0;
                led_d = led << 1;
              end else begin
                led_d = led >> 1;
              end
            end
          end
          M_HOLD: begin
`ifdef LED_CHASER_FILL_EN
            dir_d = 1'b0;
            if (fill) begin
              led_d = fill_nxt;
              if (&fill_nxt) fill_d = 1'b0;
            end else begin
              led_d = drain_nxt;
              if (drain_nxt == '0) fill_d = 1'b1;
            end
`else
            led_d = led;
`endif
          end
          default: led_d = led;
        endcase
      end else begin
        cnt_d = cnt + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      led    <= SEED;
      dir_o  <= 1'b0;
      step   <= 1'b0;
      cnt    <= '0;
      mode_q <= 2'b00;
`ifdef LED_CHASER_FILL_EN
      fill   <= 1'b1;
`endif
    end else begin
      led    <= led_d;
      dir_o  <= dir_d;
      step   <= step_d;
      cnt    <= cnt_d;
      mode_q <= mode;
`ifdef LED_CHASER_FILL_EN
      fill   <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_chaser_multi.sv
// tb/tb_led_chaser_multi.sv - self-checking bench for led_chaser_multi
module tb_led_chaser_multi;

  localparam int W = 8;
  localparam int S = 2;
  localparam int MASK = (1 << W) - 1;
  localparam int SEED = (1 << S) - 1;

  logic         clk = 1'b0;
  logic         rs_n;
  logic         en_a, en_b;
  logic [1:0]   mode_a, mode_b;
  logic [W-1:0] led_a, led_b;
  logic         step_a, step_b, dir_a, dir_b;

  always #5 clk = ~clk;

  led_chaser_multi #(.WIDTH(W), .SEED_ONES(S), .PRESC_DIV(1), .PRESC_W(2)) u_dut_a (
    .clk(clk), .rs_n(rs_n), .en(en_a), .mode(mode_a),
    .led(led_a), .step(step_a), .dir_o(dir_a)
  );

  led_chaser_multi #(.WIDTH(W), .SEED_ONES(S), .PRESC_DIV(4), .PRESC_W(3)) u_dut_b (
    .clk(clk), .rs_n(rs_n), .en(en_b), .mode(mode_b),
    .led(led_b), .step(step_b), .dir_o(dir_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: ticks since the current mode was entered, prescaler count,
  // last registered mode and the step flag.
  int         m_cnt [2];
  int         m_k   [2];
  logic [1:0] m_mq  [2];
  logic       m_step[2];
  int         divs  [2] = '{1, 4};

  function automatic int rotl(int v, int r);
    int rr;
    rr = r % W;
    return ((v << rr) | (v >> (W - rr))) & MASK;
  endfunction

  // Expected pattern after k ticks in mode m, starting from the seed.
  function automatic int exp_led(logic [1:0] m, int k);
    int p, ph, pos, t, u;
    case (m)
      2'b00: return rotl(SEED, k);
      2'b01: return rotl(SEED, W - (k % W));
      2'b10: begin
        p   = 2 * (W - S);
        ph  = k % p;
        pos = (ph <= W - S) ? ph : p - ph;
        return (SEED << pos) & MASK;
      end
      default: begin
`ifdef LED_CHASER_FILL_EN
        // Index from an empty bank: t ones while filling, then drained from the LSB.
        t = k + S;
        u = t % (2 * W);
        if (u <= W) return (1 << u) - 1;
        else return (MASK << (u - W)) & MASK;
`else
        t = 0;
        u = t;
        return SEED + u;
`endif
      end
    endcase
  endfunction

  function automatic int exp_dir(logic [1:0] m, int k);
    int p, ph;
    case (m)
      2'b00: return 0;
      2'b01: return (k > 0) ? 1 : 0;
      2'b10: begin
        p  = 2 * (W - S);
        ph = k % p;
        if (ph > W - S) return 1;
        if (ph == 0 && k > 0) return 1;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_k[i] = 0; m_mq[i] = 2'b00; m_step[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic rn, input logic e, input logic [1:0] md);
    if (!rn) begin
      m_cnt[i] = 0; m_k[i] = 0; m_mq[i] = 2'b00; m_step[i] = 1'b0;
    end else if (md != m_mq[i]) begin
      m_cnt[i] = 0; m_k[i] = 0; m_mq[i] = md; m_step[i] = 1'b0;
    end else if (e) begin
      if (m_cnt[i] == divs[i] - 1) begin
        m_cnt[i] = 0; m_k[i] = m_k[i] + 1; m_step[i] = 1'b1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1; m_step[i] = 1'b0;
      end
    end else begin
      m_step[i] = 1'b0;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string phase);
    check_val({phase, " led_a"},  32'(led_a),  32'(exp_led(m_mq[0], m_k[0])));
    check_val({phase, " dir_a"},  32'(dir_a),  32'(exp_dir(m_mq[0], m_k[0])));
    check_val({phase, " step_a"}, 32'(step_a), 32'(m_step[0]));
    check_val({phase, " led_b"},  32'(led_b),  32'(exp_led(m_mq[1], m_k[1])));
    check_val({phase, " dir_b"},  32'(dir_b),  32'(exp_dir(m_mq[1], m_k[1])));
    check_val({phase, " step_b"}, 32'(step_b), 32'(m_step[1]));
  endtask

  task automatic cyc(input string phase);
    @(posedge clk);
    model_edge(0, rs_n, en_a, mode_a);
    model_edge(1, rs_n, en_b, mode_b);
    #1;
    check_all(phase);
  endtask

  initial begin
    rs_n = 1'b1; en_a = 1'b0; en_b = 1'b0; mode_a = 2'b00; mode_b = 2'b00;
    model_reset();
    #2 rs_n = 1'b0;
    repeat (2) cyc("reset");
    check_val("reset seed", 32'(led_a), 32'h03);
    rs_n = 1'b1;

    // Rotate left with a step every cycle, dut_b counts by four.
    en_a = 1'b1; en_b = 1'b1;
    repeat (20) cyc("rotl");

    // Rotate right.
    mode_a = 2'b01;
    repeat (20) cyc("rotr");

    // Bounce through two full periods.
    mode_a = 2'b10;
    repeat (30) cyc("bounce");

    // Mode 11: hold, or fill/drain when the feature is built in.
    mode_a = 2'b11;
    repeat (40) cyc("mode11");

    // dut_b: freeze the prescaler mid-count for three cycles.
    mode_a = 2'b00;
    repeat (2) cyc("presc_run");
    en_b = 1'b0;
    repeat (3) cyc("presc_frozen");
    en_b = 1'b1;
    repeat (9) cyc("presc_resume");
    // Mode change while frozen reloads the seed and clears the count.
    en_b = 1'b0;
    repeat (2) cyc("frozen_pre");
    mode_b = 2'b01;
    repeat (2) cyc("frozen_modechg");
    check_val("frozen_modechg seed", 32'(led_b), 32'h03);
    en_b = 1'b1;
    repeat (12) cyc("after_modechg");

    // Asynchronous reset mid-run takes effect before the next edge.
    #3 rs_n = 1'b0;
    #1;
    model_reset();
    check_val("async led_a",  32'(led_a),  32'h03);
    check_val("async dir_a",  32'(dir_a),  32'h0);
    check_val("async step_a", 32'(step_a), 32'h0);
    check_val("async led_b",  32'(led_b),  32'h03);
    repeat (2) cyc("in_reset");
    rs_n = 1'b1;

    // Random enables and mode changes on both instances.
    for (int n = 0; n < 400; n++) begin
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) mode_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 23) == 0) mode_b = 2'($urandom_range(0, 3));
      cyc("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
